map_port_arbiter: RTL and testbench
===================================

MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

Interface
REQ-001 The block SHALL have parameter READ_DELAY, default 2, meaning clk edges from map address register update to map_data sample; legal range 1..15.
REQ-002 The block SHALL have parameter RESET_POLARITY_LOW, default 1, fixed at 1: reset is active-low.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports req0/req1, input, 1 each, read request from requester 0 (ball collision checker) and requester 1 (auxiliary scanner).
REQ-006 The block SHALL have ports col0/col1, input, 10 each, and row0/row1, input, 10 each, requested map column/row.
REQ-007 The block SHALL have ports ack0/ack1, output, 1 each, one-cycle completion pulses.
REQ-008 The block SHALL have ports data0/data1, output, 8 each, returned map pixel per requester.
REQ-009 The block SHALL have ports map_col, output, 10, and map_row, output, 10, registered address to map port A.
REQ-010 The block SHALL have port map_data, input, 8, map port A pixel output.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 The block SHALL have port grant_id, output, 1, index of the requester owning the current or most recent transaction.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, DONE; a 4-bit delay counter cnt; a 1-bit round-robin pointer rr.
REQ-014 In IDLE with no request asserted, the FSM SHALL stay in IDLE and hold all outputs.
REQ-015 In IDLE with exactly one request asserted, that requester SHALL be granted regardless of rr.
REQ-016 In IDLE with both requests asserted, requester rr SHALL be granted.
REQ-017 On a grant edge, the block SHALL register the winner's col/row into map_col/map_row, set grant_id to the winner, set rr to the non-winner, set cnt=1 and enter WAIT.
REQ-018 In WAIT, if cnt==READ_DELAY the block SHALL capture map_data into data<grant_id>, pulse ack<grant_id> high for exactly the following cycle and enter DONE; otherwise cnt SHALL increment.
REQ-019 In DONE, the block SHALL ignore all requests, deassert ack, and return to IDLE on the next edge.
REQ-020 Grant-to-ack-high latency SHALL be exactly READ_DELAY edges; minimum transaction period SHALL be READ_DELAY+2 cycles.
REQ-021 Requesters SHALL hold req, col and row stable until ack; address inputs SHALL be sampled only on the grant edge.
REQ-022 A request deasserted after grant SHALL NOT abort the transaction; ack still pulses and data still updates.
REQ-023 data0 SHALL change only on ack0 capture edges; data1 only on ack1 capture edges; ack0 and ack1 SHALL never be high together.
REQ-024 map_col/map_row SHALL hold their value from the grant edge through DONE and until the next grant.
REQ-025 Under continuous requests from both requesters, grants SHALL strictly alternate 0,1,0,1...

Reset
REQ-026 On reset low, the block SHALL asynchronously force state=IDLE, cnt=0, rr=0, grant_id=0, ack0=ack1=0, busy=0, data0=data1=8'h00, map_col=map_row=0.
REQ-027 Reset asserted mid-transaction SHALL abandon it with no ack; after reset release the first grant SHALL follow REQ-015/016 with rr=0.

Verification
REQ-028 READ_DELAY=2; req0 only, col0=10'h20F, row0=10'hFE, map returns 8'h26 -> map_col=10'h20F, map_row=10'hFE one edge after grant-sampling; ack0 high 2 edges after grant for 1 cycle; data0=8'h26; ack1 never high.
REQ-029 Both req0 and req1 held high from reset release -> grant order 0,1,0,1; each ack spaced 4 cycles; rr toggles per grant.
REQ-030 req1 only with map returning 8'h49, then req0 with 8'hF9 -> data1=8'h49 unchanged after the second transaction; data0=8'hF9.
REQ-031 req0 dropped one cycle after grant -> ack0 still pulses at grant+READ_DELAY; next IDLE grants only pending requesters.
REQ-032 Reset pulsed low while in WAIT -> no ack; all outputs at REQ-026 values immediately; simultaneous requests afterward grant requester 0 first.
REQ-033 READ_DELAY=1 and READ_DELAY=15 -> ack exactly 1 and 15 edges after grant; busy high from grant edge until DONE exits.

Source files
------------

// File: rtl/map_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single map RAM read port (port A).
// Latency: READ_DELAY edges from grant to ack; back-to-back transactions every READ_DELAY+2 cycles.
// Backpressure: requesters hold req/col/row until ack; losers simply wait, and requests are ignored while busy.
module map_port_arbiter #(
    parameter int READ_DELAY         = 2,
    parameter bit RESET_POLARITY_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [9:0] col0,
    input  logic [9:0] row0,
    input  logic [9:0] col1,
    input  logic [9:0] row1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] data0,
    output logic [7:0] data1,
    output logic [9:0] map_col,
    output logic [9:0] map_row,
    input  logic [7:0] map_data,
    output logic       busy,
    output logic       grant_id
);

    generate
        if (!RESET_POLARITY_LOW || READ_DELAY < 1 || READ_DELAY > 15) begin : g_bad_param
            $error("map_port_arbiter: READ_DELAY must be 1..15 and reset must be active-low");
        end
    endgenerate

    localparam logic [3:0] RD_CNT = 4'(READ_DELAY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       rr;
    logic       grant;
    logic       winner;
    logic       capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // With a single requester the pointer is ignored; it only breaks ties.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        winner    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    winner    = (req0 && req1) ? rr : req1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == RD_CNT) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            rr       <= 1'b0;
            grant_id <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            data0    <= 8'h00;
            data1    <= 8'h00;
            map_col  <= 10'd0;
            map_row  <= 10'd0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (grant) begin
                map_col  <= winner ? col1 : col0;
                map_row  <= winner ? row1 : row0;
                grant_id <= winner;
                rr       <= ~winner;
                cnt      <= 4'd1;
            end else if (state == WAIT && !capture) begin
                cnt <= cnt + 4'd1;
            end
            // Each requester's data register moves only on its own capture edge.
            if (capture) begin
                if (grant_id) begin
                    data1 <= map_data;
                    ack1  <= 1'b1;
                end else begin
                    data0 <= map_data;
                    ack0  <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_map_port_arbiter.sv
// Randomized scoreboard bench: three arbiters (READ_DELAY 2, 1, 15) share one requester stimulus;
// a cycle-count reference model queues expected acks, a negedge monitor compares every output.
module tb_map_port_arbiter;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [9:0] col0, row0, col1, row1;

    logic       ack0_w   [NI];
    logic       ack1_w   [NI];
    logic       busy_w   [NI];
    logic       gid_w    [NI];
    logic [7:0] data0_w  [NI];
    logic [7:0] data1_w  [NI];
    logic [7:0] map_data_w [NI];
    logic [9:0] map_col_w  [NI];
    logic [9:0] map_row_w  [NI];

    always #5 clk = ~clk;

    function automatic int rd_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    // Map contents: a few fixed pixels plus a hash everywhere else.
    function automatic logic [7:0] pixel(input logic [9:0] c, input logic [9:0] r);
        if (c == 10'h20F && r == 10'h0FE) return 8'h26;
        if (c == 10'h001 && r == 10'h002) return 8'h49;
        if (c == 10'h003 && r == 10'h004) return 8'hF9;
        return c[7:0] ^ {r[3:0], r[7:4]} ^ {c[9:8], r[9:8], 4'h9};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int RD = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

        // The RAM presents the pixel for the address registered RD edges before the sample edge.
        if (RD == 1) begin : g_comb
            assign map_data_w[g] = pixel(map_col_w[g], map_row_w[g]);
        end else begin : g_pipe
            logic [19:0] pipe [15];
            always @(posedge clk) begin
                pipe[0] <= {map_col_w[g], map_row_w[g]};
                for (int k = 1; k < 15; k++) pipe[k] <= pipe[k-1];
            end
            assign map_data_w[g] = pixel(pipe[RD-2][19:10], pipe[RD-2][9:0]);
        end

        map_port_arbiter #(
            .READ_DELAY(RD),
            .RESET_POLARITY_LOW(1'b1)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req0     (req0),
            .req1     (req1),
            .col0     (col0),
            .row0     (row0),
            .col1     (col1),
            .row1     (row1),
            .ack0     (ack0_w[g]),
            .ack1     (ack1_w[g]),
            .data0    (data0_w[g]),
            .data1    (data1_w[g]),
            .map_col  (map_col_w[g]),
            .map_row  (map_row_w[g]),
            .map_data (map_data_w[g]),
            .busy     (busy_w[g]),
            .grant_id (gid_w[g])
        );
    end

    typedef struct {
        logic       who;
        logic [7:0] data;
        int         ack_edge;
    } exp_t;

    exp_t       sb_q     [NI][$];
    int         n_edge   [NI] = '{default: 0};
    int         free_at  [NI] = '{default: 0};
    logic       rr_m     [NI] = '{default: 1'b0};
    logic       last_w   [NI] = '{default: 1'b0};
    logic [9:0] last_col [NI] = '{default: 10'd0};
    logic [9:0] last_row [NI] = '{default: 10'd0};
    int         rd_idx   [NI] = '{default: 0};
    logic [7:0] exp_d0   [NI] = '{default: 8'h00};
    logic [7:0] exp_d1   [NI] = '{default: 8'h00};
    int         n_cmp = 0;
    int         n_err = 0;

    // Reference model: a transaction may start on any edge at or after free_at;
    // its ack is due READ_DELAY edges later and the port frees READ_DELAY+2 edges later.
    always @(posedge clk or negedge reset) begin : model
        logic w;
        for (int i = 0; i < NI; i++) begin
            if (!reset) begin
                free_at[i]  = 0;
                rr_m[i]     = 1'b0;
                last_w[i]   = 1'b0;
                last_col[i] = 10'd0;
                last_row[i] = 10'd0;
            end else begin
                n_edge[i] = n_edge[i] + 1;
                if (n_edge[i] >= free_at[i] && (req0 || req1)) begin
                    w           = (req0 && req1) ? rr_m[i] : req1;
                    rr_m[i]     = !w;
                    last_w[i]   = w;
                    last_col[i] = w ? col1 : col0;
                    last_row[i] = w ? row1 : row0;
                    sb_q[i].push_back('{who: w, data: pixel(last_col[i], last_row[i]),
                                        ack_edge: n_edge[i] + rd_of(i)});
                    free_at[i]  = n_edge[i] + rd_of(i) + 2;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s (rd=%0d) at %0t: got %0h, expected %0h", nm, rd_of(i), $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit   due;
        exp_t it;
        for (int i = 0; i < NI; i++) begin
            if (!reset) begin
                rd_idx[i] = sb_q[i].size();
                exp_d0[i] = 8'h00;
                exp_d1[i] = 8'h00;
                chk("rst_ack0",  i, ack0_w[i],    0);
                chk("rst_ack1",  i, ack1_w[i],    0);
                chk("rst_busy",  i, busy_w[i],    0);
                chk("rst_gid",   i, gid_w[i],     0);
                chk("rst_data0", i, data0_w[i],   0);
                chk("rst_data1", i, data1_w[i],   0);
                chk("rst_col",   i, map_col_w[i], 0);
                chk("rst_row",   i, map_row_w[i], 0);
            end else begin
                due = 1'b0;
                it  = '{who: 1'b0, data: 8'h00, ack_edge: 0};
                if (rd_idx[i] < sb_q[i].size()) begin
                    it  = sb_q[i][rd_idx[i]];
                    due = (it.ack_edge == n_edge[i]);
                end
                chk("ack0", i, ack0_w[i], 32'(due && !it.who));
                chk("ack1", i, ack1_w[i], 32'(due &&  it.who));
                if (due) begin
                    if (it.who) exp_d1[i] = it.data;
                    else        exp_d0[i] = it.data;
                    rd_idx[i] = rd_idx[i] + 1;
                end
                chk("data0",    i, data0_w[i],   exp_d0[i]);
                chk("data1",    i, data1_w[i],   exp_d1[i]);
                chk("busy",     i, busy_w[i],    32'(n_edge[i] + 1 < free_at[i]));
                chk("grant_id", i, gid_w[i],     last_w[i]);
                chk("map_col",  i, map_col_w[i], last_col[i]);
                chk("map_row",  i, map_row_w[i], last_row[i]);
            end
        end
    end

    // Wait on the READ_DELAY=2 instance; a missing ack is reported by the monitor.
    task automatic wait_ack(input int k, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ((k == 0) ? ack0_w[0] : ack1_w[0]) return;
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        col0 = '0; row0 = '0; col1 = '0; row1 = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 reset = 1'b1;

        // Single requester 0 with a known pixel.
        @(negedge clk); req0 = 1'b1; col0 = 10'h20F; row0 = 10'h0FE;
        wait_ack(0, 40); req0 = 1'b0;
        repeat (3) @(negedge clk);

        // Requester 1 then requester 0; data1 must survive the second transaction.
        req1 = 1'b1; col1 = 10'h001; row1 = 10'h002;
        wait_ack(1, 40); req1 = 1'b0;
        @(negedge clk); req0 = 1'b1; col0 = 10'h003; row0 = 10'h004;
        wait_ack(0, 40); req0 = 1'b0;
        repeat (3) @(negedge clk);

        // Requester 0 withdraws one cycle after grant while requester 1 becomes pending.
        req0 = 1'b1; col0 = 10'($urandom()); row0 = 10'($urandom());
        repeat (2) @(negedge clk);
        req0 = 1'b0; req1 = 1'b1; col1 = 10'($urandom()); row1 = 10'($urandom());
        wait_ack(1, 40); req1 = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of a transaction, then both requesters held high.
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk); @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        repeat (24) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        repeat (20) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (ack0_w[0]) begin
                req0 = 1'($urandom_range(0, 1));
                col0 = 10'($urandom()); row0 = 10'($urandom());
            end else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1;
                col0 = 10'($urandom()); row0 = 10'($urandom());
            end else if (req0 && $urandom_range(0, 31) == 0) begin
                req0 = 1'b0;
            end
            if (ack1_w[0]) begin
                req1 = 1'($urandom_range(0, 1));
                col1 = 10'($urandom()); row1 = 10'($urandom());
            end else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1;
                col1 = 10'($urandom()); row1 = 10'($urandom());
            end else if (req1 && $urandom_range(0, 31) == 0) begin
                req1 = 1'b0;
            end
        end

        req0 = 1'b0; req1 = 1'b0;
        repeat (40) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
